// File: rtl/led_pkg.sv
// led_pkg: shared LED width, scheduler state encoding and round-robin index helpers.
package led_pkg;

   localparam int LED_W = 8;

   typedef enum logic {IDLE, GRANT} state_t;

   function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
      return (int'(idx) + 1 >= n) ? 3'd0 : idx + 3'd1;
   endfunction

   // First set bit of req at or after ptr, wrapping modulo n; ptr if none.
   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
      logic [2:0] sel;
      int j;
      sel = ptr;
      for (int k = 7; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= n) j -= n;
         if (k < n && req[j[2:0]]) sel = j[2:0];
      end
      return sel;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that saturates at zero and flags when it gets there.
module hold_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = cnt_q == '0;

endmodule

// File: rtl/led_scheduler.sv
// led_scheduler: round-robin arbiter sharing one LED bank among requesters,
// holding each grant for a minimum time before rotating.
module led_scheduler
   import led_pkg::*;
#(
   parameter int               NUM_REQ     = 4,
   parameter int               HOLD_CYCLES = 12000000,
   parameter logic [LED_W-1:0] IDLE_PAT    = 8'h00
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [LED_W*NUM_REQ-1:0] pat,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [LED_W-1:0]         leds,
   output logic                     busy
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);

   state_t               state_q, state_d;
   logic [2:0]           g_q, g_d, rr_q, rr_d, pick;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [LED_W-1:0]     leds_q, leds_d;
   logic [7:0]           req_ext;
   logic [LED_W*8-1:0]   pat_ext;
   logic                 any, others, take, zero;

   // A new grant is issued from IDLE, on owner release, or on expiry with a competitor waiting.
   always_comb begin
      req_ext = '0;
      req_ext[NUM_REQ-1:0] = req;
      pat_ext = '0;
      pat_ext[LED_W*NUM_REQ-1:0] = pat;
      pick = rr_pick(req_ext, rr_q, NUM_REQ);
      any = |req;
      others = |(req & ~gnt_q);
      take = (state_q == IDLE || !req_ext[g_q]) ? any : (zero && others);
      state_d = take ? GRANT : (state_q == GRANT && !req_ext[g_q]) ? IDLE : state_q;
      g_d = take ? pick : g_q;
      rr_d = take ? rr_next(pick, NUM_REQ) : rr_q;
      for (int i = 0; i < NUM_REQ; i++) gnt_d[i] = state_d == GRANT && g_d == 3'(i);
      leds_d = (state_d == GRANT) ? pat_ext[{g_d, 3'b000} +: LED_W] : IDLE_PAT;
   end

   hold_timer #(.W(CW)) u_hold (
      .clk        (clk),
      .rst        (rst),
      .load_i     (take),
      .load_val_i (CW'(HOLD_CYCLES - 1)),
      .en_i       (state_q == GRANT),
      .zero_o     (zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         g_q     <= '0;
         rr_q    <= '0;
         gnt_q   <= '0;
         leds_q  <= IDLE_PAT;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         leds_q  <= leds_d;
      end
   end

   assign gnt  = gnt_q;
   assign leds = leds_q;
   assign busy = state_q == GRANT;

endmodule
